// File: rtl/ysyx_22040088_genmemwdata_if.sv
// Bundle of store request, memory write beat and completion signals.
// master = store data generator, slave = LSU control plus data memory.
interface ysyx_22040088_genmemwdata_if #(
    parameter int AW = 64,
    parameter int DW = 64
);
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic [3:0]    req_mask;

    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [7:0]    wr_strb;

    logic          resp_valid;
    logic          resp_err;

    modport master (
        input  req_valid, req_addr, req_data, req_mask,
        output req_ready,
        output wr_valid, wr_addr, wr_data, wr_strb,
        input  wr_ready,
        output resp_valid, resp_err
    );

    modport slave (
        output req_valid, req_addr, req_data, req_mask,
        input  req_ready,
        input  wr_valid, wr_addr, wr_data, wr_strb,
        output wr_ready,
        input  resp_valid, resp_err
    );
endinterface

// File: rtl/ysyx_22040088_genmemwdata.sv
// Store data generator: aligns register data into 64-bit lanes, issues write beats, pulses a response.
// Define YSYX_22040088_STORE_SPLIT_EN to split 8-byte-boundary-crossing stores into two beats.
module ysyx_22040088_genmemwdata #(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    ysyx_22040088_genmemwdata_if.master   bus
);

`ifdef YSYX_22040088_STORE_SPLIT_EN
    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
`else
    typedef enum logic [1:0] {IDLE, BEAT0, RESP} state_t;
`endif

    state_t        state;

    logic          mask_zero;
    logic [7:0]    low_strb;
    logic [DW-1:0] byte_keep;
    logic [DW-1:0] masked_data;
    logic [2:0]    sh;
    logic [5:0]    shamt;
    logic [15:0]   strb16;
    logic          crossing;
    logic [AW-1:0] base_addr;
    logic [DW-1:0] lane_lo;
`ifdef YSYX_22040088_STORE_SPLIT_EN
    logic [2*DW-1:0] data128;
    logic [DW-1:0]   lane_hi;
    logic [DW-1:0]   hi_data;
    logic [7:0]      hi_strb;
`endif

    // Size decode (lowest mask bit wins) and lane placement of the incoming request.
    always_comb begin
        mask_zero = 1'b0;
        low_strb  = 8'h00;
        byte_keep = '0;
        if (bus.req_mask[0]) begin
            low_strb  = 8'hFF;
            byte_keep = {DW{1'b1}};
        end else if (bus.req_mask[1]) begin
            low_strb  = 8'h0F;
            byte_keep = DW'(64'h0000_0000_FFFF_FFFF);
        end else if (bus.req_mask[2]) begin
            low_strb  = 8'h03;
            byte_keep = DW'(64'h0000_0000_0000_FFFF);
        end else if (bus.req_mask[3]) begin
            low_strb  = 8'h01;
            byte_keep = DW'(64'h0000_0000_0000_00FF);
        end else begin
            mask_zero = 1'b1;
        end

        sh          = bus.req_addr[2:0];
        shamt       = {sh, 3'b000};
        masked_data = bus.req_data & byte_keep;
        strb16      = {8'h00, low_strb} << sh;
        crossing    = |strb16[15:8];
        base_addr   = {bus.req_addr[AW-1:3], 3'b000};
`ifdef YSYX_22040088_STORE_SPLIT_EN
        data128     = {{DW{1'b0}}, masked_data} << shamt;
        lane_lo     = data128[DW-1:0];
        lane_hi     = data128[2*DW-1:DW];
`else
        lane_lo     = masked_data << shamt;
`endif
    end

    // Control FSM; every bus output is a register so beats stay stable under stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            bus.req_ready  <= 1'b1;
            bus.wr_valid   <= 1'b0;
            bus.wr_addr    <= '0;
            bus.wr_data    <= '0;
            bus.wr_strb    <= 8'h00;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
`ifdef YSYX_22040088_STORE_SPLIT_EN
            hi_data        <= '0;
            hi_strb        <= 8'h00;
`endif
        end else begin
            case (state)
                IDLE: begin
                    bus.resp_valid <= 1'b0;
                    if (bus.req_valid) begin
                        bus.req_ready <= 1'b0;
                        if (mask_zero) begin
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
`ifndef YSYX_22040088_STORE_SPLIT_EN
                        end else if (crossing) begin
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
`endif
                        end else begin
                            state        <= BEAT0;
                            bus.wr_valid <= 1'b1;
                            bus.wr_addr  <= base_addr;
                            bus.wr_data  <= lane_lo;
                            bus.wr_strb  <= strb16[7:0];
                            bus.resp_err <= 1'b0;
`ifdef YSYX_22040088_STORE_SPLIT_EN
                            hi_data      <= lane_hi;
                            hi_strb      <= strb16[15:8];
`else
                            if (crossing) begin
                                bus.resp_err <= 1'b1;
                            end
`endif
                        end
                    end
                end

                BEAT0: begin
                    if (bus.wr_ready) begin
`ifdef YSYX_22040088_STORE_SPLIT_EN
                        if (|hi_strb) begin
                            state       <= BEAT1;
                            bus.wr_addr <= bus.wr_addr + AW'(8);
                            bus.wr_data <= hi_data;
                            bus.wr_strb <= hi_strb;
                        end else begin
                            state          <= RESP;
                            bus.wr_valid   <= 1'b0;
                            bus.resp_valid <= 1'b1;
                        end
`else
                        state          <= RESP;
                        bus.wr_valid   <= 1'b0;
                        bus.resp_valid <= 1'b1;
`endif
                    end
                end

`ifdef YSYX_22040088_STORE_SPLIT_EN
                BEAT1: begin
                    if (bus.wr_ready) begin
                        state          <= RESP;
                        bus.wr_valid   <= 1'b0;
                        bus.resp_valid <= 1'b1;
                    end
                end
`endif

                RESP: begin
                    state          <= IDLE;
                    bus.resp_valid <= 1'b0;
                    bus.resp_err   <= 1'b0;
                    bus.req_ready  <= 1'b1;
                end

                default: begin
                    state          <= IDLE;
                    bus.wr_valid   <= 1'b0;
                    bus.resp_valid <= 1'b0;
                    bus.resp_err   <= 1'b0;
                    bus.req_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040088_genmemwdata.sv
// Directed bench for ysyx_22040088_genmemwdata; expectations follow YSYX_22040088_STORE_SPLIT_EN.
module tb_ysyx_22040088_genmemwdata;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    logic accepted;

    ysyx_22040088_genmemwdata_if #(.AW(64), .DW(64)) bus ();

    ysyx_22040088_genmemwdata #(.AW(64), .DW(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one request and hold it until accepted, giving up after 20 cycles.
    task automatic applyStimulus(input logic [63:0] addr, input logic [63:0] data, input logic [3:0] mask);
        logic rdy;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_data  = data;
        bus.req_mask  = mask;
        accepted      = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rdy = bus.req_ready;
            @(posedge clk);
            #1;
            if (rdy === 1'b1) begin
                accepted = 1'b1;
                break;
            end
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic saw_resp;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 1'b1 || bus.wr_valid !== 1'b0 || bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_ctrl: got ready=%b wv=%b rv=%b re=%b, want 1 0 0 0",
                     bus.req_ready, bus.wr_valid, bus.resp_valid, bus.resp_err);
        end
        n_cmp++;
        if (bus.wr_addr !== 64'h0 || bus.wr_data !== 64'h0 || bus.wr_strb !== 8'h00) begin
            n_err++;
            $display("[TB] FAIL reset_beat: got addr=%h data=%h strb=%h, want all zero",
                     bus.wr_addr, bus.wr_data, bus.wr_strb);
        end

        bus.wr_ready = 1'b0;
        applyStimulus(64'h8000_0000, 64'h0102_0304_0506_0708, 4'b0001);
        @(negedge clk);
        n_cmp++;
        if (accepted !== 1'b1 || bus.wr_valid !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL abort_setup: got acc=%b wv=%b, want 1 1", accepted, bus.wr_valid);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.wr_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL abort_state: got wv=%b ready=%b rv=%b, want 0 1 0",
                     bus.wr_valid, bus.req_ready, bus.resp_valid);
        end
        saw_resp = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1 || bus.wr_valid === 1'b1) saw_resp = 1'b1;
        end
        n_cmp++;
        if (saw_resp !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL abort_no_resp: got activity=%b, want 0", saw_resp);
        end
    endtask

    task automatic test_single_beat();
        bus.wr_ready = 1'b1;
        applyStimulus(64'h8000_0004, 64'h1122_3344_5566_7788, 4'b0010);
        @(negedge clk);
        n_cmp++;
        if (accepted !== 1'b1 || bus.wr_valid !== 1'b1 || bus.req_ready !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL single_ctrl: got acc=%b wv=%b ready=%b, want 1 1 0",
                     accepted, bus.wr_valid, bus.req_ready);
        end
        n_cmp++;
        if (bus.wr_addr !== 64'h8000_0000 || bus.wr_strb !== 8'hF0 || bus.wr_data !== 64'h5566_7788_0000_0000) begin
            n_err++;
            $display("[TB] FAIL single_beat: got addr=%h strb=%h data=%h, want 80000000 f0 5566778800000000",
                     bus.wr_addr, bus.wr_strb, bus.wr_data);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0 || bus.wr_valid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL single_resp: got rv=%b re=%b wv=%b, want 1 0 0",
                     bus.resp_valid, bus.resp_err, bus.wr_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL single_idle: got rv=%b ready=%b, want 0 1", bus.resp_valid, bus.req_ready);
        end
    endtask

    task automatic test_stall();
        int resp_count;
        bus.wr_ready = 1'b0;
        applyStimulus(64'h8000_0003, 64'h0000_0000_0000_00AB, 4'b1000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (accepted !== 1'b1 || bus.wr_valid !== 1'b1 || bus.wr_addr !== 64'h8000_0000 ||
                bus.wr_strb !== 8'h08 || bus.wr_data !== 64'h0000_0000_AB00_0000 || bus.resp_valid !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL stall_hold[%0d]: got wv=%b addr=%h strb=%h data=%h rv=%b, want 1 80000000 08 00000000ab000000 0",
                         i, bus.wr_valid, bus.wr_addr, bus.wr_strb, bus.wr_data, bus.resp_valid);
            end
            @(posedge clk);
        end
        #1;
        bus.wr_ready = 1'b1;
        resp_count = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1) resp_count++;
        end
        n_cmp++;
        if (resp_count !== 1) begin
            n_err++;
            $display("[TB] FAIL stall_resp_count: got %0d pulses, want 1", resp_count);
        end
    endtask

    task automatic test_crossing();
        bus.wr_ready = 1'b1;
        applyStimulus(64'h8000_0006, 64'h0000_0000_DEAD_BEEF, 4'b0010);
        @(negedge clk);
`ifdef YSYX_22040088_STORE_SPLIT_EN
        n_cmp++;
        if (accepted !== 1'b1 || bus.wr_valid !== 1'b1 || bus.wr_addr !== 64'h8000_0000 ||
            bus.wr_strb !== 8'hC0 || bus.wr_data !== 64'hBEEF_0000_0000_0000) begin
            n_err++;
            $display("[TB] FAIL split_beat0: got wv=%b addr=%h strb=%h data=%h, want 1 80000000 c0 beef000000000000",
                     bus.wr_valid, bus.wr_addr, bus.wr_strb, bus.wr_data);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.wr_valid !== 1'b1 || bus.wr_addr !== 64'h8000_0008 ||
            bus.wr_strb !== 8'h03 || bus.wr_data !== 64'h0000_0000_0000_DEAD || bus.resp_valid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL split_beat1: got wv=%b addr=%h strb=%h data=%h rv=%b, want 1 80000008 03 000000000000dead 0",
                     bus.wr_valid, bus.wr_addr, bus.wr_strb, bus.wr_data, bus.resp_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0 || bus.wr_valid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL split_resp: got rv=%b re=%b wv=%b, want 1 0 0",
                     bus.resp_valid, bus.resp_err, bus.wr_valid);
        end
`else
        n_cmp++;
        if (accepted !== 1'b1 || bus.wr_valid !== 1'b0 || bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL cross_reject: got acc=%b wv=%b rv=%b re=%b, want 1 0 1 1",
                     accepted, bus.wr_valid, bus.resp_valid, bus.resp_err);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.wr_valid !== 1'b0 || bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL cross_after: got wv=%b rv=%b ready=%b, want 0 0 1",
                     bus.wr_valid, bus.resp_valid, bus.req_ready);
        end
`endif
    endtask

    task automatic test_priority();
        bus.wr_ready = 1'b1;
        applyStimulus(64'h8000_0000, 64'h1122_3344_5566_7788, 4'b0110);
        @(negedge clk);
        n_cmp++;
        if (accepted !== 1'b1 || bus.wr_valid !== 1'b1 || bus.wr_strb !== 8'h0F || bus.wr_data !== 64'h0000_0000_5566_7788) begin
            n_err++;
            $display("[TB] FAIL prio_word: got wv=%b strb=%h data=%h, want 1 0f 0000000055667788",
                     bus.wr_valid, bus.wr_strb, bus.wr_data);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL prio_resp: got rv=%b re=%b, want 1 0", bus.resp_valid, bus.resp_err);
        end
        applyStimulus(64'h8000_0002, 64'hFFFF_FFFF_FFFF_CAFE, 4'b0100);
        @(negedge clk);
        n_cmp++;
        if (accepted !== 1'b1 || bus.wr_strb !== 8'h0C || bus.wr_data !== 64'h0000_0000_CAFE_0000) begin
            n_err++;
            $display("[TB] FAIL half_lane: got acc=%b strb=%h data=%h, want 1 0c 00000000cafe0000",
                     accepted, bus.wr_strb, bus.wr_data);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bus.wr_ready = 1'b1;
        applyStimulus(64'h8000_0020, 64'h1234_5678_9ABC_DEF0, 4'b0000);
        @(negedge clk);
        n_cmp++;
        if (accepted !== 1'b1 || bus.wr_valid !== 1'b0 || bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL zero_mask: got acc=%b wv=%b rv=%b re=%b, want 1 0 1 1",
                     accepted, bus.wr_valid, bus.resp_valid, bus.resp_err);
        end
        applyStimulus(64'h8000_0010, 64'h0123_4567_89AB_CDEF, 4'b0001);
        @(negedge clk);
        n_cmp++;
        if (accepted !== 1'b1 || bus.wr_valid !== 1'b1 || bus.wr_addr !== 64'h8000_0010 ||
            bus.wr_strb !== 8'hFF || bus.wr_data !== 64'h0123_4567_89AB_CDEF) begin
            n_err++;
            $display("[TB] FAIL b2b_beat: got acc=%b wv=%b addr=%h strb=%h data=%h, want 1 1 80000010 ff 0123456789abcdef",
                     accepted, bus.wr_valid, bus.wr_addr, bus.wr_strb, bus.wr_data);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL b2b_resp: got rv=%b re=%b, want 1 0", bus.resp_valid, bus.resp_err);
        end
        @(negedge clk);
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        accepted      = 1'b0;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.req_mask  = 4'b0000;
        bus.wr_ready  = 1'b0;

        test_reset();
        test_single_beat();
        test_stall();
        test_crossing();
        test_priority();
        test_back_to_back();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
